multi_channel_dwell_timer: RTL and testbench
============================================

// Module: multi_channel_dwell_timer
// PURPOSE
//   NCH independent down-counting dwell timers for photonic switch sequencing. Each channel
//   loads a dwell limit and counts down on its enable, then flags expiry with a done pulse.
//   Channels run one-shot or auto-reload. Adds synchronous load, abort, reset, busy/done
//   status and multi-channel packing. Sits between the switch command decoder and the
//   switch drivers.
// PARAMETERS
//   WIDTH  16  counter / limit width per channel (>=2)
//   NCH    4   number of independent channels (>=1)
// PORTS
//   clk          in   1          system clock, all state updates on posedge
//   rst_n        in   1          reset, asynchronous, active-low
//   load         in   NCH        per-channel synchronous load strobe
//   limit        in   NCH*WIDTH  packed limits, channel i = limit[i*WIDTH +: WIDTH]
//   en           in   NCH        per-channel count enable (decrement qualifier)
//   reload_mode  in   NCH        1 = auto-reload at expiry, 0 = one-shot
//   abort        in   NCH        per-channel synchronous abort
//   count        out  NCH*WIDTH  packed current count, same packing as limit
//   busy         out  NCH        channel is running (count loaded and not expired)
//   done         out  NCH        one-cycle expiry pulse (registered)
//   any_busy     out  1          OR of busy (combinational)
// BEHAVIOUR
// - Reset (rst_n=0, async): count=0, busy=0, done=0, stored reload value rld=0 on all channels.
// - Channels are fully independent; each has 2 states: IDLE (busy=0), RUN (busy=1).
// - Priority per channel per edge: abort > load > decrement/expiry > hold.
// - abort: count<=0, busy<=0, done<=0 next cycle; rld unchanged. Applies in any state.
// - load (no abort): rld<=limit_i, count<=limit_i. Legal in IDLE or RUN (RUN restarts).
//     limit_i!=0 -> busy<=1 (RUN). limit_i==0 -> busy<=0, done<=1 for one cycle after the edge.
//     Load takes effect regardless of en. Load in same cycle as terminal count: load wins,
//     no done pulse.
// - RUN, en=1, count>1: count<=count-1, done<=0.
// - RUN, en=1, count==1 (terminal): done<=1 for exactly one cycle, coincident with the
//     cycle after the edge. reload_mode sampled at this edge:
//     0 -> count<=0, busy<=0 (IDLE). 1 -> count<=rld, busy stays 1 (no dead cycle).
// - RUN, en=0: count, busy hold; done<=0.
// - IDLE, en=1, no load: count holds at 0 (no wrap to all-ones, ever); done<=0.
// - Latency: after load of L>0, expiry needs exactly L enabled cycles; done is high in the
//     cycle count reads 0 (one-shot) or reads rld (reload).
// - done is never high for 2 consecutive cycles except auto-reload with rld==1 and en held
//     high (expires every cycle).
// - Arithmetic is unsigned, WIDTH bits; limit of all-ones is legal (2^WIDTH-1 enabled cycles).
// - Outputs count, busy, done are registered; any_busy is the only combinational output.
// - Asynchronous reset mid-count discards state immediately; no done is issued.
// TESTING
// - Ch0 load limit=5, en=1 steady, one-shot -> count 5,4,3,2,1,0; done high one cycle when
//     count=0; busy falls same cycle; count stays 0 afterwards.
// - Ch1 load limit=3, reload_mode=1, en=1 -> done every 3rd cycle, count 3,2,1,3,2,1...,
//     busy never drops; drop reload_mode before expiry -> stops at 0 with final done.
// - Ch2 load 4, toggle en 1,0,1,0... -> count decrements only on en=1 cycles; done after 4
//     enabled cycles (8 clocks); ch0/ch3 unaffected.
// - Ch0 at count=1 with en=1: assert load limit=7 same cycle -> count=7, no done; separately
//     assert abort+load same cycle -> count=0, busy=0, no done.
// - Load limit=0 -> busy stays 0, single done pulse next cycle; load all-ones on WIDTH=4
//     build -> 15 enabled cycles to done, no wrap below 0.
// - Pull rst_n low mid-count on all channels (not clock-aligned) -> count=0, busy=0, done=0
//     immediately; after release, channels idle until next load.

Source files
------------

// File: rtl/multi_channel_dwell_timer.sv
// NCH independent down-counting dwell timers with one-shot / auto-reload expiry,
// synchronous load/abort and a registered one-cycle done pulse per channel.
module multi_channel_dwell_timer #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         load,
  input  logic [NCH*WIDTH-1:0]   limit,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         reload_mode,
  input  logic [NCH-1:0]         abort,
  output logic [NCH*WIDTH-1:0]   count,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         done,
  output logic                   any_busy
);

  // Per-channel state; the state bit is what busy reports, so busy is the
  // externally visible view of each channel's FSM.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [NCH-1:0]            state_q, state_d;
  logic [NCH-1:0]            done_q,  done_d;
  logic [NCH-1:0][WIDTH-1:0] count_q, count_d;
  logic [NCH-1:0][WIDTH-1:0] rld_q,   rld_d;

  // Priority per channel: abort > load > decrement/expiry > hold.
  // RUN always carries a nonzero count, so the terminal test is count == 1.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rld_d   = rld_q;
    done_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (abort[i]) begin
        state_d[i] = ST_IDLE;
        count_d[i] = CNT_ZERO;
      end else if (load[i]) begin
        rld_d[i]   = limit[i*WIDTH +: WIDTH];
        count_d[i] = limit[i*WIDTH +: WIDTH];
        if (limit[i*WIDTH +: WIDTH] != CNT_ZERO) begin
          state_d[i] = ST_RUN;
        end else begin
          state_d[i] = ST_IDLE;
          done_d[i]  = 1'b1;
        end
      end else if (state_q[i] == ST_RUN && en[i]) begin
        if (count_q[i] == CNT_ONE) begin
          done_d[i] = 1'b1;
          if (reload_mode[i]) begin
            count_d[i] = rld_q[i];
          end else begin
            count_d[i] = CNT_ZERO;
            state_d[i] = ST_IDLE;
          end
        end else begin
          count_d[i] = count_q[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      rld_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      count_q <= count_d;
      rld_q   <= rld_d;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NCH; i++) begin
      count[i*WIDTH +: WIDTH] = count_q[i];
    end
  end

  assign busy     = state_q;
  assign done     = done_q;
  assign any_busy = |state_q;

endmodule

// File: tb/tb_multi_channel_dwell_timer.sv
// Directed plus randomized bench for multi_channel_dwell_timer on a WIDTH=4, NCH=4 build,
// checked against a channel-level reference model and fixed expected values.
module tb_multi_channel_dwell_timer;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   ld, en, rm, ab;
  logic [N*W-1:0] lim;
  logic [N*W-1:0] count;
  logic [N-1:0]   busy, done;
  logic           any_busy;

  always #5 clk = ~clk;

  multi_channel_dwell_timer #(.WIDTH(W), .NCH(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ld),
    .limit       (lim),
    .en          (en),
    .reload_mode (rm),
    .abort       (ab),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .any_busy    (any_busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: remaining count, remembered reload value, running flag, done pulse.
  int m_cnt[N];
  int m_rld[N];
  bit m_run[N];
  bit m_done[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_rld[i] = 0; m_run[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      int l;
      l = int'(lim[i*W +: W]);
      m_done[i] = 0;
      if (ab[i]) begin
        m_cnt[i] = 0; m_run[i] = 0;
      end else if (ld[i]) begin
        m_rld[i] = l; m_cnt[i] = l;
        m_run[i]  = (l != 0);
        m_done[i] = (l == 0);
      end else if (m_run[i] && en[i]) begin
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0) begin
          m_done[i] = 1;
          if (rm[i]) m_cnt[i] = m_rld[i];
          else       m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    bit any;
    any = 0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("count[%0d]", i), 32'(count[i*W +: W]), 32'(m_cnt[i]));
      chk($sformatf("busy[%0d]", i),  32'(busy[i]),         32'(m_run[i]));
      chk($sformatf("done[%0d]", i),  32'(done[i]),         32'(m_done[i]));
      any |= m_run[i];
    end
    chk("any_busy", 32'(any_busy), 32'(any));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_lim(input int ch, input int val);
    lim[ch*W +: W] = val[W-1:0];
  endtask

  function automatic logic [W-1:0] cnt_of(input int ch);
    return count[ch*W +: W];
  endfunction

  initial begin
    rst_n = 1'b0;
    ld = '0; en = '0; rm = '0; ab = '0; lim = '0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // One-shot limit 5 on channel 0.
    set_lim(0, 5); ld[0] = 1'b1; en[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    chk("ch0_load5_count", 32'(cnt_of(0)), 32'd5);
    repeat (5) tick();
    chk("ch0_expire_count", 32'(cnt_of(0)), 32'd0);
    chk("ch0_expire_done",  32'(done[0]),   32'd1);
    chk("ch0_expire_busy",  32'(busy[0]),   32'd0);
    repeat (2) tick();
    chk("ch0_after_done",  32'(done[0]),   32'd0);
    chk("ch0_after_count", 32'(cnt_of(0)), 32'd0);
    en[0] = 1'b0;

    // Auto-reload limit 3 on channel 1, then drop reload before expiry.
    set_lim(1, 3); ld[1] = 1'b1; rm[1] = 1'b1; en[1] = 1'b1;
    tick();
    ld[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("ch1_reload_busy", 32'(busy[1]), 32'd1);
      chk("ch1_reload_done", 32'(done[1]), 32'((k % 3) == 0));
    end
    rm[1] = 1'b0;
    repeat (2) tick();
    chk("ch1_final_done",  32'(done[1]),   32'd1);
    chk("ch1_final_count", 32'(cnt_of(1)), 32'd0);
    chk("ch1_final_busy",  32'(busy[1]),   32'd0);
    en[1] = 1'b0;

    // Channel 2 with en toggling: four enabled cycles over eight clocks.
    set_lim(2, 4); ld[2] = 1'b1;
    tick();
    ld[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      en[2] = (k % 2 == 0);
      tick();
      chk("ch2_toggle_done", 32'(done[2]), 32'(k == 6));
      chk("ch0_untouched", 32'(cnt_of(0)), 32'd0);
    end
    en[2] = 1'b0;

    // Load at terminal count wins; abort beats load.
    set_lim(0, 3); ld[0] = 1'b1; en[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    repeat (2) tick();
    chk("ch0_at_one", 32'(cnt_of(0)), 32'd1);
    set_lim(0, 7); ld[0] = 1'b1;
    tick();
    chk("ch0_reload_count", 32'(cnt_of(0)), 32'd7);
    chk("ch0_reload_nodone", 32'(done[0]), 32'd0);
    set_lim(0, 9); ab[0] = 1'b1;
    tick();
    ld[0] = 1'b0; ab[0] = 1'b0;
    chk("ch0_abort_count", 32'(cnt_of(0)), 32'd0);
    chk("ch0_abort_busy",  32'(busy[0]),   32'd0);
    chk("ch0_abort_done",  32'(done[0]),   32'd0);
    en[0] = 1'b0;

    // Zero limit: immediate single done, never busy.
    set_lim(3, 0); ld[3] = 1'b1; en[3] = 1'b1;
    tick();
    ld[3] = 1'b0;
    chk("ch3_zero_done", 32'(done[3]), 32'd1);
    chk("ch3_zero_busy", 32'(busy[3]), 32'd0);
    tick();
    chk("ch3_zero_done_clr", 32'(done[3]), 32'd0);

    // All-ones limit: 15 enabled cycles, no wrap below zero.
    set_lim(3, 15); ld[3] = 1'b1;
    tick();
    ld[3] = 1'b0;
    repeat (14) tick();
    chk("ch3_max_pre", 32'(done[3]), 32'd0);
    tick();
    chk("ch3_max_done", 32'(done[3]), 32'd1);
    repeat (2) tick();
    chk("ch3_max_nowrap", 32'(cnt_of(3)), 32'd0);

    // Randomized traffic on all channels.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        ld[i] = ($urandom_range(0, 9) == 0);
        ab[i] = ($urandom_range(0, 24) == 0);
        en[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) rm[i] = ~rm[i];
        set_lim(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)));
      end
      tick();
    end
    ld = '0; ab = '0;

    // Asynchronous reset mid-count, off the clock edge.
    for (int i = 0; i < N; i++) set_lim(i, 10);
    ld = '1; en = '1; rm = '0;
    tick();
    ld = '0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_any_busy", 32'(any_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
